text_screen_buffer: RTL

//  Parametrised character buffer between CPU and text engine: ROWS x COLS cells of CHAR_W bits.

---
 rtl/text_screen_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/text_screen_buffer.sv
// Character cell buffer shared by a CPU and a text engine. It accepts raw indexed writes and
// cursor-based commands, and sweeps memory one cell per clock for clear and scroll.
module text_screen_buffer #(
    parameter int unsigned          COLS      = 16,
    parameter int unsigned          ROWS      = 4,
    parameter int unsigned          CHAR_W    = 8,
    parameter logic [CHAR_W-1:0]    FILL_CHAR = CHAR_W'(8'h20),
    localparam int unsigned         DEPTH     = COLS * ROWS,
    localparam int unsigned         AW        = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [CHAR_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_op_i,
    input  logic [CHAR_W-1:0] cmd_data_i,
    output logic              cmd_ready_o,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [CHAR_W-1:0] rd_data_o,
    output logic [AW-1:0]     cursor_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned AW1 = AW + 1;

    localparam logic [AW:0] DepthW   = AW1'(DEPTH);
    localparam logic [AW:0] LastW    = AW1'(DEPTH - 1);
    localparam logic [AW:0] LastRowW = AW1'((ROWS - 1) * COLS);
    localparam logic [AW:0] ColsW    = AW1'(COLS);
    localparam logic [AW:0] SrcEndW  = AW1'(DEPTH - COLS);

    localparam logic [CHAR_W-1:0] NlChar = CHAR_W'(8'h0A);

    localparam logic [1:0] OpPutc   = 2'd0;
    localparam logic [1:0] OpClear  = 2'd1;
    localparam logic [1:0] OpScroll = 2'd2;
    localparam logic [1:0] OpSetCur = 2'd3;

    typedef enum logic [1:0] {StIdle, StClear, StScroll} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       cursor_q, cursor_d;
    logic                done_q, done_d;
    logic [CHAR_W-1:0]   rd_data_q;
    logic [CHAR_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [CHAR_W-1:0]   mem_wdata;

    logic [AW:0]         cur_w;
    logic [AW:0]         idx_w;
    logic [AW:0]         nl_next_w;
    logic [AW:0]         src_w;
    logic [AW:0]         set_w;

    assign cur_w     = {1'b0, cursor_q};
    assign idx_w     = {1'b0, idx_q};
    assign nl_next_w = cur_w - (cur_w % ColsW) + ColsW;
    assign src_w     = idx_w + ColsW;
    assign set_w     = {1'b0, AW'(cmd_data_i)};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cursor_d  = cursor_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state_q)
            StIdle: begin
                // A command takes priority; a simultaneous raw write is not accepted.
                if (cmd_valid_i) begin
                    unique case (cmd_op_i)
                        OpPutc: begin
                            if (cmd_data_i == NlChar) begin
                                if (cur_w >= LastRowW) begin
                                    state_d  = StScroll;
                                    idx_d    = '0;
                                    cursor_d = AW'(LastRowW);
                                end else begin
                                    cursor_d = AW'(nl_next_w);
                                end
                            end else begin
                                mem_we    = 1'b1;
                                mem_waddr = cursor_q;
                                mem_wdata = cmd_data_i;
                                if (cur_w == LastW) begin
                                    state_d  = StScroll;
                                    idx_d    = '0;
                                    cursor_d = AW'(LastRowW);
                                end else begin
                                    cursor_d = AW'(cur_w + 1'b1);
                                end
                            end
                        end
                        OpClear: begin
                            state_d  = StClear;
                            idx_d    = '0;
                            cursor_d = '0;
                        end
                        OpScroll: begin
                            state_d  = StScroll;
                            idx_d    = '0;
                            cursor_d = AW'(LastRowW);
                        end
                        OpSetCur: begin
                            cursor_d = (set_w > LastW) ? AW'(LastW) : AW'(set_w);
                        end
                        default: ;
                    endcase
                end else if (wr_en_i && ({1'b0, wr_addr_i} < DepthW)) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr_i;
                    mem_wdata = wr_data_i;
                end
            end
            StClear, StScroll: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                // Ascending order means the source row has not been overwritten yet.
                if (state_q == StScroll && idx_w < SrcEndW) begin
                    mem_wdata = mem_q[AW'(src_w)];
                end else begin
                    mem_wdata = FILL_CHAR;
                end
                if (idx_w == LastW) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    idx_d = AW'(idx_w + 1'b1);
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StClear;
            idx_q     <= '0;
            cursor_q  <= '0;
            done_q    <= 1'b0;
            rd_data_q <= FILL_CHAR;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cursor_q  <= cursor_d;
            done_q    <= done_d;
            rd_data_q <= ({1'b0, rd_addr_i} < DepthW) ? mem_q[rd_addr_i] : FILL_CHAR;
        end
    end

    // Cell storage is deliberately unreset; the post-reset clear sweep initialises it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign wr_ready_o  = (state_q == StIdle) && !cmd_valid_i;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign cursor_o    = cursor_q;
    assign rd_data_o   = rd_data_q;

endmodule
